// File: rtl/rr_select4_arb_pkg.sv
// Shared definitions for the 4-requester round-robin bit-select arbiter.
package rr_select4_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Binary requester index to one-hot grant vector.
  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_select4_arb_pick4.sv
// Combinational round-robin picker: first set request after the pointer wins,
// the pointer position itself is searched last.
module rr_pick4
  import rr_select4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             any_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [SEL_W-1:0] cand1_s;
  logic [SEL_W-1:0] cand2_s;
  logic [SEL_W-1:0] cand3_s;

  // Modulo-4 wrap comes for free from the 2-bit adds.
  assign cand1_s = ptr_i + 2'd1;
  assign cand2_s = ptr_i + 2'd2;
  assign cand3_s = ptr_i + 2'd3;

  // Priority search in rotated order starting just after the last owner.
  always_comb begin
    any_o = 1'b0;
    idx_o = ptr_i;
    if (req_i[cand1_s]) begin
      any_o = 1'b1;
      idx_o = cand1_s;
    end else if (req_i[cand2_s]) begin
      any_o = 1'b1;
      idx_o = cand2_s;
    end else if (req_i[cand3_s]) begin
      any_o = 1'b1;
      idx_o = cand3_s;
    end else if (req_i[ptr_i]) begin
      any_o = 1'b1;
      idx_o = ptr_i;
    end else begin
      any_o = 1'b0;
      idx_o = ptr_i;
    end
  end

endmodule

// File: rtl/rr_select4_arb.sv
// Round-robin arbiter sharing one 4:1 bit-select path among four requesters.
// Tenures are bounded to MAX_HOLD cycles and separated by one dead cycle.
module rr_select4_arb
  import rr_select4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  din,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             dout,
  output logic             busy
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e       state_q;
  logic [HOLD_W-1:0] cnt_q;
  logic [SEL_W-1:0] ptr_q;
  logic [NREQ-1:0]  gnt_q;
  logic [SEL_W-1:0] sel_q;
  logic             busy_q;
  logic             dout_q;

  logic             pick_any_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic             mux_bit_s;
  logic             tenure_end_s;

  rr_pick4 u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .any_o (pick_any_s),
    .idx_o (pick_idx_s)
  );

  // Shared 4:1 bit-select driven by the registered select.
  assign mux_bit_s = din[sel_q];

  // Owner releases or the tenure counter reaches its last cycle.
  assign tenure_end_s = (!req[sel_q]) || (cnt_q == HOLD_LAST);

  // Arbitration FSM with registered grant, select, busy, counter and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, GAP: begin
          if (pick_any_s) begin
            state_q <= GRANT;
            gnt_q   <= idx_to_onehot(pick_idx_s);
            sel_q   <= pick_idx_s;
            ptr_q   <= pick_idx_s;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (tenure_end_s) begin
            // sel keeps pointing at the last owner through the gap
            state_q <= GAP;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Output data register: granted bit from the previous cycle, else 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= busy_q ? mux_bit_s : 1'b0;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_rr_select4_arb.sv
// Directed self-checking bench for rr_select4_arb. Three instances share the
// stimulus and differ only in MAX_HOLD (8, 2, 3).
module tb_rr_select4_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;

  logic [3:0] gnt8, gnt2, gnt3;
  logic [1:0] sel8, sel2, sel3;
  logic       dout8, dout2, dout3;
  logic       busy8, busy2, busy3;

  int checks = 0;
  int errors = 0;

  rr_select4_arb #(.MAX_HOLD(8), .HOLD_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt8), .sel(sel8), .dout(dout8), .busy(busy8)
  );

  rr_select4_arb #(.MAX_HOLD(2), .HOLD_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt2), .sel(sel2), .dout(dout2), .busy(busy2)
  );

  rr_select4_arb #(.MAX_HOLD(3), .HOLD_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt3), .sel(sel3), .dout(dout3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] fair_gnt [13];
  logic [3:0] exp_gnt  [8];

  initial begin
    fair_gnt = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0,
                 4'h8, 4'h8, 4'h0, 4'h1};
    exp_gnt  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};

    // Reset and idle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_gnt",  {4'h0, gnt8},  8'h00);
      chk("idle_sel",  {6'h0, sel8},  8'h00);
      chk("idle_busy", {7'h0, busy8}, 8'h00);
      chk("idle_dout", {7'h0, dout8}, 8'h00);
    end

    // Single requester 2, release after three grant cycles, din[2] = 1,0,1
    req = 4'b0100;
    din = 4'b0100;
    tick();
    chk("single_gnt",  {4'h0, gnt8},  8'h04);
    chk("single_sel",  {6'h0, sel8},  8'h02);
    chk("single_busy", {7'h0, busy8}, 8'h01);
    chk("single_dout0", {7'h0, dout8}, 8'h00);
    tick();
    chk("single_dout1", {7'h0, dout8}, 8'h01);
    chk("single_gnt1",  {4'h0, gnt8},  8'h04);
    din = 4'b0000;
    tick();
    chk("single_dout2", {7'h0, dout8}, 8'h00);
    chk("single_gnt2",  {4'h0, gnt8},  8'h04);
    din = 4'b0100;
    req = 4'b0000;
    tick();
    chk("release_gnt",  {4'h0, gnt8},  8'h00);
    chk("release_busy", {7'h0, busy8}, 8'h00);
    chk("release_dout", {7'h0, dout8}, 8'h01);
    chk("release_sel",  {6'h0, sel8},  8'h02);
    din = 4'b0000;
    tick();
    chk("gap_gnt",  {4'h0, gnt8},  8'h00);
    chk("gap_dout", {7'h0, dout8}, 8'h00);
    chk("gap_sel",  {6'h0, sel8},  8'h02);
    tick();
    chk("back_idle_gnt", {4'h0, gnt8}, 8'h00);

    // Round-robin fairness, MAX_HOLD=2, all requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("fair_gnt",  {4'h0, gnt2},  {4'h0, fair_gnt[i]});
      chk("fair_busy", {7'h0, busy2}, {7'h0, |fair_gnt[i]});
    end

    // Expiry with a sole requester, MAX_HOLD=3
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("expiry_gnt", {4'h0, gnt3}, {4'h0, exp_gnt[i]});
    end
    chk("expiry_sel", {6'h0, sel3}, 8'h00);

    // Owner 1 releases while requester 3 raises in the same cycle
    do_reset();
    req = 4'b0010;
    tick();
    chk("swap_gnt0", {4'h0, gnt8}, 8'h02);
    chk("swap_sel0", {6'h0, sel8}, 8'h01);
    req = 4'b1000;
    tick();
    chk("swap_gap_gnt", {4'h0, gnt8}, 8'h00);
    chk("swap_gap_sel", {6'h0, sel8}, 8'h01);
    tick();
    chk("swap_gnt1",  {4'h0, gnt8},  8'h08);
    chk("swap_sel1",  {6'h0, sel8},  8'h03);
    chk("swap_busy1", {7'h0, busy8}, 8'h01);

    // Asynchronous reset in the middle of a tenure of requester 1
    do_reset();
    req = 4'b0010;
    din = 4'b0010;
    tick();
    chk("mid_gnt", {4'h0, gnt8}, 8'h02);
    tick();
    chk("mid_dout", {7'h0, dout8}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("async_gnt",  {4'h0, gnt8},  8'h00);
    chk("async_busy", {7'h0, busy8}, 8'h00);
    chk("async_dout", {7'h0, dout8}, 8'h00);
    chk("async_sel",  {6'h0, sel8},  8'h00);
    req = 4'b0011;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", {4'h0, gnt8}, 8'h01);
    chk("post_rst_sel", {6'h0, sel8}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
